// File: rtl/phase_ctrl_pkg.sv
// Shared constants for the phase scheduler: FSM state encoding and default sizing.
package phase_ctrl_pkg;

  localparam int DEF_W       = 16;
  localparam int DEF_LATENCY = 188;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PULSE   = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_HALT    = 3'd4;

endpackage

// File: rtl/sample_skid_buf.sv
// One-entry holding register for a 4-channel sample that arrives while a conversion is in flight.
module sample_skid_buf
  import phase_ctrl_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           clr_i,
  input  logic           wr_i,
  input  logic           rd_i,
  input  logic [4*W-1:0] wr_data_i,
  output logic [4*W-1:0] rd_data_o,
  output logic           full_o
);

  logic [4*W-1:0] data_q, data_d;
  logic           full_q, full_d;

  // A simultaneous read and write hands out the old entry and keeps the new one.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (clr_i) begin
      full_d = 1'b0;
    end else if (wr_i) begin
      data_d = wr_data_i;
      full_d = 1'b1;
    end else if (rd_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign rd_data_o = data_q;
  assign full_o    = full_q;

endmodule

// File: rtl/phase_scheduler.sv
// Sequencer in front of all_phase: launches one conversion per accepted sample, waits the fixed
// latency, captures the six phase differences and manages burst / overrun bookkeeping.
module phase_scheduler
  import phase_ctrl_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int LATENCY = DEF_LATENCY,
  parameter int CNT_W   = 16,
  parameter int OVR_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             smp_valid,
  input  logic [W-1:0]     smp_rx1,
  input  logic [W-1:0]     smp_rx2,
  input  logic [W-1:0]     smp_rx3,
  input  logic [W-1:0]     smp_rx4,
  output logic             ph_enable,
  output logic [W-1:0]     ph_rx1,
  output logic [W-1:0]     ph_rx2,
  output logic [W-1:0]     ph_rx3,
  output logic [W-1:0]     ph_rx4,
  input  logic [W-1:0]     ph_diff1,
  input  logic [W-1:0]     ph_diff2,
  input  logic [W-1:0]     ph_diff3,
  input  logic [W-1:0]     ph_diff4,
  input  logic [W-1:0]     ph_diff5,
  input  logic [W-1:0]     ph_diff6,
  output logic [W-1:0]     out_diff1,
  output logic [W-1:0]     out_diff2,
  output logic [W-1:0]     out_diff3,
  output logic [W-1:0]     out_diff4,
  output logic [W-1:0]     out_diff5,
  output logic [W-1:0]     out_diff6,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [OVR_W-1:0] overrun_cnt
);

  localparam int               LCW       = $clog2(LATENCY);
  localparam logic [LCW-1:0]   WAIT_LAST = LCW'(LATENCY - 1);

  function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
    return (&v) ? v : v + OVR_W'(1);
  endfunction

  logic [2:0]          state_q, state_d;
  logic [LCW-1:0]      wait_q, wait_d;
  logic                run_q;
  logic [CNT_W-1:0]    burst_q, burst_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [OVR_W-1:0]    ovr_q, ovr_d;
  logic [3:0][W-1:0]   rx_q, rx_d;
  logic [5:0][W-1:0]   diff_q, diff_d;
  logic                en_q, en_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;

  logic [3:0][W-1:0]   smp_pack;
  logic [5:0][W-1:0]   ph_diff_pack;
  logic [4*W-1:0]      skid_data;
  logic                skid_full, skid_rd, skid_wr;
  logic                run_rise, direct, smp_ok, overrun;

  assign smp_pack     = {smp_rx4, smp_rx3, smp_rx2, smp_rx1};
  assign ph_diff_pack = {ph_diff6, ph_diff5, ph_diff4, ph_diff3, ph_diff2, ph_diff1};
  assign run_rise     = run & ~run_q;
  assign cnt_inc      = cnt_q + CNT_W'(1);

  // Samples outside a run or after a finished burst are ignored entirely.
  assign smp_ok  = smp_valid & run & (state_q != ST_HALT);
  assign skid_wr = smp_ok & ~direct & (~skid_full | skid_rd);
  assign overrun = smp_ok & ~direct & skid_full & ~skid_rd;

  sample_skid_buf #(.W(W)) u_skid (
    .clk_i     (clock),
    .rst_ni    (reset),
    .clr_i     (~run),
    .wr_i      (skid_wr),
    .rd_i      (skid_rd),
    .wr_data_i (smp_pack),
    .rd_data_o (skid_data),
    .full_o    (skid_full)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    rx_d    = rx_q;
    diff_d  = diff_q;
    en_d    = 1'b0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    skid_rd = 1'b0;
    direct  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          if (skid_full) begin
            skid_rd = 1'b1;
            rx_d    = skid_data;
            en_d    = 1'b1;
            state_d = ST_PULSE;
          end else if (smp_valid) begin
            direct  = 1'b1;
            rx_d    = smp_pack;
            en_d    = 1'b1;
            state_d = ST_PULSE;
          end
        end
      end
      ST_PULSE: begin
        wait_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = ST_CAPTURE;
        else                     wait_d  = wait_q + LCW'(1);
      end
      ST_CAPTURE: begin
        diff_d  = ph_diff_pack;
        valid_d = 1'b1;
        cnt_d   = cnt_inc;
        if ((burst_q != '0) && (cnt_inc == burst_q)) begin
          done_d  = 1'b1;
          state_d = ST_HALT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
        if (run_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A new run restarts the bookkeeping; this takes priority over same-cycle updates.
    if (run_rise) begin
      cnt_d   = '0;
      ovr_d   = '0;
      burst_d = burst_len;
    end else if (overrun) begin
      ovr_d = sat_inc(ovr_q);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      run_q   <= 1'b0;
      burst_q <= '0;
      cnt_q   <= '0;
      ovr_q   <= '0;
      rx_q    <= '0;
      diff_q  <= '0;
      en_q    <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      run_q   <= run;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      rx_q    <= rx_d;
      diff_q  <= diff_d;
      en_q    <= en_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign ph_enable   = en_q;
  assign ph_rx1      = rx_q[0];
  assign ph_rx2      = rx_q[1];
  assign ph_rx3      = rx_q[2];
  assign ph_rx4      = rx_q[3];
  assign out_diff1   = diff_q[0];
  assign out_diff2   = diff_q[1];
  assign out_diff3   = diff_q[2];
  assign out_diff4   = diff_q[3];
  assign out_diff5   = diff_q[4];
  assign out_diff6   = diff_q[5];
  assign out_valid   = valid_q;
  assign done        = done_q;
  assign busy        = (state_q == ST_PULSE) || (state_q == ST_WAIT) || (state_q == ST_CAPTURE);
  assign sample_cnt  = cnt_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// Bench for phase_scheduler: stand-in all_phase, conversion-level reference model, directed stimulus.
module tb_phase_scheduler;
  localparam int W = 16, LATENCY = 188, CNT_W = 16, OVR_W = 8;

  logic clock = 1'b0, reset = 1'b1, run = 1'b0, smp_valid = 1'b0;
  logic [CNT_W-1:0] burst_len = '0;
  logic [W-1:0] smp_rx1 = '0, smp_rx2 = '0, smp_rx3 = '0, smp_rx4 = '0;
  logic ph_enable, out_valid, busy, done;
  logic [W-1:0] ph_rx1, ph_rx2, ph_rx3, ph_rx4;
  logic [W-1:0] apd [6];
  logic [W-1:0] out_diff1, out_diff2, out_diff3, out_diff4, out_diff5, out_diff6;
  logic [CNT_W-1:0] sample_cnt;
  logic [OVR_W-1:0] overrun_cnt;

  int total = 0, bad = 0, nv = 0, nd = 0, ne = 0;

  always #5 clock = ~clock;

  phase_scheduler #(.W(W), .LATENCY(LATENCY), .CNT_W(CNT_W), .OVR_W(OVR_W)) dut (
    .clock(clock), .reset(reset), .run(run), .burst_len(burst_len), .smp_valid(smp_valid),
    .smp_rx1(smp_rx1), .smp_rx2(smp_rx2), .smp_rx3(smp_rx3), .smp_rx4(smp_rx4),
    .ph_enable(ph_enable), .ph_rx1(ph_rx1), .ph_rx2(ph_rx2), .ph_rx3(ph_rx3), .ph_rx4(ph_rx4),
    .ph_diff1(apd[0]), .ph_diff2(apd[1]), .ph_diff3(apd[2]),
    .ph_diff4(apd[3]), .ph_diff5(apd[4]), .ph_diff6(apd[5]),
    .out_diff1(out_diff1), .out_diff2(out_diff2), .out_diff3(out_diff3),
    .out_diff4(out_diff4), .out_diff5(out_diff5), .out_diff6(out_diff6),
    .out_valid(out_valid), .busy(busy), .done(done),
    .sample_cnt(sample_cnt), .overrun_cnt(overrun_cnt)
  );

  function automatic logic [W-1:0] pair_diff(input logic [W-1:0] r0, r1, r2, r3, input int k);
    case (k)
      0: return r0 - r1;
      1: return r0 - r2;
      2: return r0 - r3;
      3: return r1 - r2;
      4: return r1 - r3;
      default: return r2 - r3;
    endcase
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Stand-in all_phase: garbage until LATENCY cycles after ph_enable, then pairwise differences.
  int ap_cnt = 0;
  logic [W-1:0] ap_rx [4];
  always @(posedge clock) begin
    if (ph_enable) begin
      ap_rx[0] = ph_rx1; ap_rx[1] = ph_rx2; ap_rx[2] = ph_rx3; ap_rx[3] = ph_rx4;
      ap_cnt = 1;
      for (int k = 0; k < 6; k++) apd[k] <= W'(16'h5A5A + k);
    end else if (ap_cnt != 0) begin
      ap_cnt++;
      if (ap_cnt == LATENCY) begin
        for (int k = 0; k < 6; k++) apd[k] <= pair_diff(ap_rx[0], ap_rx[1], ap_rx[2], ap_rx[3], k);
        ap_cnt = 0;
      end
    end
  end

  // Reference model: a conversion occupies the scheduler from its accept edge to accept+LATENCY+2.
  int cyc = 0, m_acc = 0;
  bit m_active = 0, m_halted = 0, m_skid = 0, m_prev_run = 0;
  bit m_rise, m_free, m_consume, m_direct, m_wr;
  logic [W-1:0] m_rx [4] = '{default: '0};
  logic [W-1:0] m_skid_rx [4] = '{default: '0};
  logic [W-1:0] e_diff [6] = '{default: '0};
  logic e_en = 0, e_valid = 0, e_done = 0;
  logic [CNT_W-1:0] e_cnt = '0, m_burst = '0, m_inc;
  logic [OVR_W-1:0] e_ovr = '0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_active = 0; m_halted = 0; m_skid = 0; m_prev_run = 0;
      e_en = 0; e_valid = 0; e_done = 0; e_cnt = '0; e_ovr = '0; m_burst = '0;
      for (int k = 0; k < 4; k++) m_rx[k] = '0;
      for (int k = 0; k < 6; k++) e_diff[k] = '0;
    end else begin
      cyc++;
      m_rise    = run && !m_prev_run;
      m_free    = !m_active && !m_halted;
      m_consume = m_free && run && m_skid;
      m_direct  = m_free && run && !m_skid && smp_valid;
      m_wr      = smp_valid && run && !m_halted && !m_direct;
      e_en = 0; e_valid = 0; e_done = 0;
      if (m_halted && m_rise) m_halted = 0;
      if (m_active && cyc == m_acc + LATENCY + 2) begin
        e_valid = 1;
        for (int k = 0; k < 6; k++) e_diff[k] = pair_diff(m_rx[0], m_rx[1], m_rx[2], m_rx[3], k);
        m_active = 0;
        m_inc = e_cnt + 1'b1;
        if (m_burst != 0 && m_inc == m_burst) begin e_done = 1; m_halted = 1; end
        e_cnt = m_inc;
      end
      if (m_consume) begin
        m_rx = m_skid_rx;
        m_skid = 0;
      end else if (m_direct) begin
        m_rx[0] = smp_rx1; m_rx[1] = smp_rx2; m_rx[2] = smp_rx3; m_rx[3] = smp_rx4;
      end
      if (m_consume || m_direct) begin m_active = 1; m_acc = cyc; e_en = 1; end
      if (m_wr) begin
        if (!m_skid) begin
          m_skid = 1;
          m_skid_rx[0] = smp_rx1; m_skid_rx[1] = smp_rx2; m_skid_rx[2] = smp_rx3; m_skid_rx[3] = smp_rx4;
        end else if (e_ovr != {OVR_W{1'b1}}) begin
          e_ovr = e_ovr + 1'b1;
        end
      end
      if (!run) m_skid = 0;
      if (m_rise) begin e_cnt = '0; e_ovr = '0; m_burst = burst_len; end
      m_prev_run = run;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    check("ph_enable", ph_enable, e_en);
    check("ph_rx1", ph_rx1, m_rx[0]);
    check("ph_rx2", ph_rx2, m_rx[1]);
    check("ph_rx3", ph_rx3, m_rx[2]);
    check("ph_rx4", ph_rx4, m_rx[3]);
    check("out_valid", out_valid, e_valid);
    check("done", done, e_done);
    check("busy", busy, m_active);
    check("sample_cnt", sample_cnt, e_cnt);
    check("overrun_cnt", overrun_cnt, e_ovr);
    check("out_diff1", out_diff1, e_diff[0]);
    check("out_diff2", out_diff2, e_diff[1]);
    check("out_diff3", out_diff3, e_diff[2]);
    check("out_diff4", out_diff4, e_diff[3]);
    check("out_diff5", out_diff5, e_diff[4]);
    check("out_diff6", out_diff6, e_diff[5]);
    if (out_valid) nv++;
    if (done) nd++;
    if (ph_enable) ne++;
  end

  task automatic send(input logic [W-1:0] a, b, c, d);
    @(negedge clock);
    smp_valid = 1'b1; smp_rx1 = a; smp_rx2 = b; smp_rx3 = c; smp_rx4 = d;
    @(negedge clock);
    smp_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm, input int lim, output int n);
    n = 0;
    while (n < lim) begin
      @(negedge clock);
      n++;
      if (out_valid) return;
    end
    total++; bad++;
    $display("FAIL %s: no out_valid within %0d cycles", nm, lim);
  endtask

  logic [W-1:0] tbl [4] = '{16'd0, 16'd5004, 16'd9890, 16'd14545};

  initial begin
    int n, ne0, nv0, nd0;
    #1 reset = 1'b0;
    // reset held with sample activity
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      smp_valid = ~smp_valid;
      smp_rx1 = W'(i * 100); smp_rx2 = W'(i); smp_rx3 = W'(i + 3); smp_rx4 = W'(i * 7);
    end
    @(negedge clock);
    smp_valid = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_no_enable", ne, 0);
    run = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    check("idle_busy", busy, 0);
    check("idle_no_enable", ne, 0);

    // single sample, continuous mode
    burst_len = '0;
    run = 1'b1;
    repeat (2) @(negedge clock);
    send(16'd5004, 16'd5004, 16'd5004, 16'd5004);
    check("single_enable", ph_enable, 1);
    wait_valid("single", 400, n);
    check("single_latency", n, LATENCY + 2);
    check("single_diff1", out_diff1, 0);
    check("single_cnt", sample_cnt, 1);

    // overrun: second sample via skid, third dropped
    send(16'd100, 16'd200, 16'd300, 16'd400);
    repeat (8) @(negedge clock);
    send(16'd1000, 16'hFC18, 16'd2000, 16'hF830);
    repeat (8) @(negedge clock);
    send(16'd7, 16'd7, 16'd7, 16'd7);
    wait_valid("ovr_first", 400, n);
    check("ovr_first_lat", n, LATENCY + 2 - 20);
    @(negedge clock);
    check("skid_enable", ph_enable, 1);
    check("skid_rx2", ph_rx2, 16'hFC18);
    check("ovr_one", overrun_cnt, 1);
    wait_valid("skid_result", 400, n);
    check("skid_diff1", out_diff1, 16'd2000);

    // flood of samples saturates the overrun counter
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      smp_valid = 1'b1;
      smp_rx1 = W'(i); smp_rx2 = W'(3 * i); smp_rx3 = W'(i + 11); smp_rx4 = W'(500 - i);
    end
    @(negedge clock);
    smp_valid = 1'b0;
    check("ovr_sat", overrun_cnt, 255);

    // stop mid-conversion with skid full: result emitted, buffered sample discarded
    run = 1'b0;
    wait_valid("stop_result", 400, n);
    ne0 = ne;
    repeat (200) @(negedge clock);
    check("stop_no_enable", ne, ne0);
    check("stop_busy", busy, 0);

    // burst of 3 with a fourth sample arriving in HALT
    burst_len = CNT_W'(3);
    run = 1'b1;
    @(negedge clock);
    check("burst_cnt_clr", sample_cnt, 0);
    check("burst_ovr_clr", overrun_cnt, 0);
    nv0 = nv; nd0 = nd;
    for (int k = 0; k < 4; k++) begin
      send(tbl[k % 4], tbl[(k + 1) % 4], tbl[(k + 2) % 4], tbl[(k + 3) % 4]);
      if (k < 3) repeat (189) @(negedge clock);
    end
    repeat (200) @(negedge clock);
    check("burst_valids", nv - nv0, 3);
    check("burst_dones", nd - nd0, 1);
    check("burst_cnt", sample_cnt, 3);
    check("burst_diff1", out_diff1, 16'hEDD1);
    check("burst_diff6", out_diff6, 16'hEC74);
    check("halt_busy", busy, 0);

    // leaving HALT needs run to drop and rise again
    run = 1'b0;
    repeat (2) @(negedge clock);
    burst_len = '0;
    run = 1'b1;
    @(negedge clock);
    send(16'd1, 16'd2, 16'd3, 16'd4);
    wait_valid("rerun", 400, n);
    check("rerun_diff3", out_diff3, 16'hFFFD);
    check("rerun_cnt", sample_cnt, 1);

    // asynchronous reset in the middle of a conversion
    send(16'd9, 16'd8, 16'd7, 16'd6);
    repeat (50) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("areset_busy", busy, 0);
    check("areset_rx1", ph_rx1, 0);
    check("areset_cnt", sample_cnt, 0);
    check("areset_diff3", out_diff3, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    nv0 = nv;
    repeat (250) @(negedge clock);
    check("areset_no_valid", nv, nv0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
